lcd_refresh_engine: RTL and testbench

Parametrised HD44780-class character-LCD controller with an integrated power-up/initialisation sequence, an internal LINES×CHARS character buffer written through a simple host port, and per-line dirty tracking, so only changed lines are re-sent to the panel. It sits between the calculator display formatters and the LCD pins. It is the successor to the separate initialiser/driver pair and the combinational `display_chars` array. All panel timing is counted in `clk` cycles from parameters, so the same RTL serves any panel geometry and clock rate.

---
 rtl/lcd_refresh_engine.sv | 270 +++++++++++++++++++++++++++
 tb/tb_lcd_refresh_engine.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_refresh_engine.sv
`default_nettype none
// ============================================================================
// Module      : lcd_refresh_engine
// Description : HD44780-class character LCD controller. Power-up wait, init
//               command sequence, LINES x CHARS character buffer written by a
//               host port, and per-line dirty tracking so that only changed
//               lines are re-sent. All panel timing is counted in clk cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_refresh_engine #(
    parameter int                 LINES          = 4,
    parameter int                 CHARS          = 20,
    parameter logic [7*LINES-1:0] LINE_STARTS    = {7'h00, 7'h40, 7'h14, 7'h54},
    parameter int                 POWERUP_CYC    = 2_000_000,
    parameter int                 E_HIGH_CYC     = 25,
    parameter int                 CMD_WAIT_CYC   = 2500,
    parameter int                 CLEAR_WAIT_CYC = 100_000,
    localparam int                LINE_W         = (LINES > 1) ? $clog2(LINES) : 1,
    localparam int                COL_W          = (CHARS > 1) ? $clog2(CHARS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [7:0]        wr_char,
    output logic              init_done,
    output logic              busy,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic              lcd_e,
    output logic [7:0]        lcd_data
);

    localparam int MAX_A   = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_B   = (CMD_WAIT_CYC > E_HIGH_CYC) ? CMD_WAIT_CYC : E_HIGH_CYC;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_PWRUP   = 3'd0,
        S_INIT    = 3'd1,
        S_IDLE    = 3'd2,
        S_SETADDR = 3'd3,
        S_WRCHAR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP = 2'd0,
        PH_EHIGH = 2'd1,
        PH_WAIT  = 2'd2
    } phase_t;

    state_t             r_state, w_state_nxt;
    phase_t             r_phase, w_phase_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_wait_last;
    logic [2:0]         r_step, w_step_nxt;
    logic [COL_W-1:0]   r_col, w_col_nxt;
    logic [LINE_W-1:0]  r_line, w_line_nxt, w_sel_line;
    logic               r_e, w_e_nxt;
    logic               r_init_done, w_init_nxt;
    logic               r_busy;
    logic [7:0]         r_hold_data, w_hold_data_nxt;
    logic               r_hold_rs, w_hold_rs_nxt;
    logic               w_sel;
    logic [7:0]         w_byte;
    logic               w_rs;
    logic [6:0]         w_start;
    logic               w_in_txn;
    logic               w_line_ok, w_col_ok, w_wr_ok;
    logic [LINES-1:0]   r_dirty, w_dirty_nxt;
    logic [7:0]         r_buf [LINES][CHARS];

    // A power-of-two geometry makes every encodable index valid
    if (LINES == (1 << LINE_W)) begin : g_line_full
        assign w_line_ok = 1'b1;
    end else begin : g_line_chk
        assign w_line_ok = (wr_line < LINE_W'(LINES));
    end

    if (CHARS == (1 << COL_W)) begin : g_col_full
        assign w_col_ok = 1'b1;
    end else begin : g_col_chk
        assign w_col_ok = (wr_col < COL_W'(CHARS));
    end

    assign w_wr_ok  = wr_en & w_line_ok & w_col_ok;
    assign w_in_txn = (r_state == S_INIT) || (r_state == S_SETADDR) || (r_state == S_WRCHAR);

    // Byte and register-select for the transaction currently being issued
    always_comb begin
        w_start = 7'h00;
        for (int i = 0; i < LINES; i++) begin
            if (r_line == LINE_W'(i)) w_start = LINE_STARTS[7*(LINES-1-i) +: 7];
        end
        w_byte = 8'h20;
        w_rs   = 1'b0;
        case (r_state)
            S_INIT: begin
                case (r_step)
                    3'd0, 3'd1: w_byte = 8'h38;
                    3'd2:       w_byte = 8'h0C;
                    3'd3:       w_byte = 8'h06;
                    default:    w_byte = 8'h01;
                endcase
            end
            S_SETADDR: w_byte = {1'b1, w_start};
            S_WRCHAR: begin
                w_byte = r_buf[r_line][r_col];
                w_rs   = 1'b1;
            end
            default: ;
        endcase
    end

    // Lowest-index dirty line wins the next refresh slot
    always_comb begin
        w_sel_line = '0;
        for (int i = LINES - 1; i >= 0; i--) begin
            if (r_dirty[i]) w_sel_line = LINE_W'(i);
        end
    end

    // Next-state logic: power-up wait, idle arbitration and the shared
    // setup / E-high / wait transaction sequencer
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_cnt_nxt       = r_cnt;
        w_step_nxt      = r_step;
        w_col_nxt       = r_col;
        w_line_nxt      = r_line;
        w_e_nxt         = r_e;
        w_init_nxt      = r_init_done;
        w_hold_data_nxt = r_hold_data;
        w_hold_rs_nxt   = r_hold_rs;
        w_sel           = 1'b0;
        w_wait_last     = (r_state == S_INIT && r_step == 3'd4) ?
                          CNT_W'(CLEAR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
        case (r_state)
            S_PWRUP: begin
                if (r_cnt == CNT_W'(POWERUP_CYC - 1)) begin
                    w_state_nxt = S_INIT;
                    w_phase_nxt = PH_SETUP;
                    w_cnt_nxt   = '0;
                    w_step_nxt  = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (|r_dirty) begin
                    w_sel       = 1'b1;
                    w_line_nxt  = w_sel_line;
                    w_state_nxt = S_SETADDR;
                    w_phase_nxt = PH_SETUP;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                case (r_phase)
                    PH_SETUP: begin
                        // Latch the bus value so it stays put through E and the wait
                        w_e_nxt         = 1'b1;
                        w_phase_nxt     = PH_EHIGH;
                        w_cnt_nxt       = '0;
                        w_hold_data_nxt = w_byte;
                        w_hold_rs_nxt   = w_rs;
                    end
                    PH_EHIGH: begin
                        if (r_cnt == CNT_W'(E_HIGH_CYC - 1)) begin
                            w_e_nxt     = 1'b0;
                            w_phase_nxt = PH_WAIT;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (r_cnt == w_wait_last) begin
                            w_phase_nxt = PH_SETUP;
                            w_cnt_nxt   = '0;
                            case (r_state)
                                S_INIT: begin
                                    if (r_step == 3'd4) begin
                                        w_init_nxt  = 1'b1;
                                        w_state_nxt = S_IDLE;
                                    end else begin
                                        w_step_nxt = r_step + 3'd1;
                                    end
                                end
                                S_SETADDR: begin
                                    w_state_nxt = S_WRCHAR;
                                    w_col_nxt   = '0;
                                end
                                default: begin
                                    if (r_col == COL_W'(CHARS - 1)) w_state_nxt = S_IDLE;
                                    else                            w_col_nxt   = r_col + 1'b1;
                                end
                            endcase
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                endcase
            end
        endcase
    end

    // Dirty update: a host write to a line beats a simultaneous selection clear
    always_comb begin
        w_dirty_nxt = r_dirty;
        if (w_sel)   w_dirty_nxt[w_sel_line] = 1'b0;
        if (w_wr_ok) w_dirty_nxt[wr_line]    = 1'b1;
    end

    // Controller state, panel strobe and status registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_PWRUP;
            r_phase     <= PH_SETUP;
            r_cnt       <= '0;
            r_step      <= '0;
            r_col       <= '0;
            r_line      <= '0;
            r_e         <= 1'b0;
            r_init_done <= 1'b0;
            r_busy      <= 1'b1;
            r_hold_data <= 8'h00;
            r_hold_rs   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_cnt       <= w_cnt_nxt;
            r_step      <= w_step_nxt;
            r_col       <= w_col_nxt;
            r_line      <= w_line_nxt;
            r_e         <= w_e_nxt;
            r_init_done <= w_init_nxt;
            r_busy      <= !w_init_nxt || (w_state_nxt != S_IDLE) || (|w_dirty_nxt);
            r_hold_data <= w_hold_data_nxt;
            r_hold_rs   <= w_hold_rs_nxt;
        end
    end

    // Character buffer and dirty flags; contents return to spaces on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dirty <= '1;
            for (int l = 0; l < LINES; l++) begin
                for (int c = 0; c < CHARS; c++) begin
                    r_buf[l][c] <= 8'h20;
                end
            end
        end else begin
            r_dirty <= w_dirty_nxt;
            if (w_wr_ok) r_buf[wr_line][wr_col] <= wr_char;
        end
    end

    // During setup the bus shows the live byte; afterwards the latched copy
    assign lcd_data  = (w_in_txn && r_phase == PH_SETUP) ? w_byte : r_hold_data;
    assign lcd_rs    = (w_in_txn && r_phase == PH_SETUP) ? w_rs   : r_hold_rs;
    assign lcd_rw    = 1'b0;
    assign lcd_e     = r_e;
    assign init_done = r_init_done;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_lcd_refresh_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_refresh_engine
// Description : Directed self-checking bench for lcd_refresh_engine
//               (2x4 main instance plus a 1x3 instance for range checks).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_refresh_engine;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       wr_en   = 1'b0;
    logic       wr_line = 1'b0;
    logic [1:0] wr_col  = 2'd0;
    logic [7:0] wr_char = 8'h00;
    logic       init_done, busy, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    logic       wr_en2   = 1'b0;
    logic       wr_line2 = 1'b0;
    logic [1:0] wr_col2  = 2'd0;
    logic [7:0] wr_char2 = 8'h00;
    logic       init_done2, busy2, lcd_rs2, lcd_rw2, lcd_e2;
    logic [7:0] lcd_data2;

    lcd_refresh_engine #(
        .LINES(2), .CHARS(4), .LINE_STARTS({7'h00, 7'h40}),
        .POWERUP_CYC(10), .E_HIGH_CYC(2), .CMD_WAIT_CYC(4), .CLEAR_WAIT_CYC(8)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_line(wr_line), .wr_col(wr_col),
        .wr_char(wr_char), .init_done(init_done), .busy(busy), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data)
    );

    lcd_refresh_engine #(
        .LINES(1), .CHARS(3), .LINE_STARTS(7'h00),
        .POWERUP_CYC(10), .E_HIGH_CYC(2), .CMD_WAIT_CYC(4), .CLEAR_WAIT_CYC(8)
    ) dut2 (
        .clk(clk), .reset(reset), .wr_en(wr_en2), .wr_line(wr_line2), .wr_col(wr_col2),
        .wr_char(wr_char2), .init_done(init_done2), .busy(busy2), .lcd_rs(lcd_rs2),
        .lcd_rw(lcd_rw2), .lcd_e(lcd_e2), .lcd_data(lcd_data2)
    );

    always #5 clk = ~clk;

    // Cycle number relative to reset release: edge 1 is the first rising edge
    int cyc = 0;
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Capture every E rise of the main panel: bus value plus the edge it rose on
    logic       prev_e = 1'b0;
    logic [7:0] q_d [$];
    logic       q_rs[$];
    int         q_c [$];
    always @(negedge clk) begin
        if (lcd_e && !prev_e) begin
            q_d.push_back(lcd_data);
            q_rs.push_back(lcd_rs);
            q_c.push_back(cyc);
        end
        prev_e = lcd_e;
    end

    logic prev_e2  = 1'b0;
    int   n_rise2  = 0;
    always @(negedge clk) begin
        if (lcd_e2 && !prev_e2) n_rise2 = n_rise2 + 1;
        prev_e2 = lcd_e2;
    end

    int n_tests = 0;
    int n_fail  = 0;
    bit aborted = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_txn(input string tag, input logic exp_rs, input logic [7:0] exp_d,
                              input int exp_c);
        int         t;
        logic [7:0] d;
        logic       rs;
        int         c;
        t = 0;
        while (q_d.size() == 0 && !aborted && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (q_d.size() == 0) begin
            aborted = 1'b1;
            check({tag, "_timeout"}, 32'(q_d.size()), 32'd1);
        end else begin
            d  = q_d.pop_front();
            rs = q_rs.pop_front();
            c  = q_c.pop_front();
            check({tag, "_data"}, 32'(d), 32'(exp_d));
            check({tag, "_rs"}, 32'(rs), 32'(exp_rs));
            if (exp_c >= 0) check({tag, "_cyc"}, 32'(c), 32'(exp_c));
        end
    endtask

    task automatic expect_line(input string tag, input logic [7:0] addr,
                               input logic [31:0] chars, input int addr_c);
        logic [31:0] v;
        v = chars;
        expect_txn({tag, "_addr"}, 1'b0, addr, addr_c);
        for (int i = 0; i < 4; i++)
            expect_txn($sformatf("%s_c%0d", tag, i), 1'b1, v[31-8*i -: 8], -1);
    endtask

    task automatic wait_busy_low(input string tag, input int exp_c);
        int t;
        t = 0;
        while (busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_busy"}, 32'(busy), 32'd0);
        if (exp_c >= 0) check({tag, "_cyc"}, 32'(cyc), 32'(exp_c));
    endtask

    task automatic write1(input logic l, input logic [1:0] c, input logic [7:0] ch);
        wr_en = 1'b1; wr_line = l; wr_col = c; wr_char = ch;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write2(input logic l, input logic [1:0] c, input logic [7:0] ch);
        wr_en2 = 1'b1; wr_line2 = l; wr_col2 = c; wr_char2 = ch;
        @(negedge clk);
        wr_en2 = 1'b0;
    endtask

    // Full power-up: five init commands, init_done, then both lines as spaces
    task automatic boot_check(input string pfx);
        for (int t = 0; t < 200 && !init_done; t++) @(negedge clk);
        check({pfx, "_init_done_cyc"}, 32'(cyc), 32'd49);
        expect_txn({pfx, "_init0"}, 1'b0, 8'h38, 11);
        expect_txn({pfx, "_init1"}, 1'b0, 8'h38, 18);
        expect_txn({pfx, "_init2"}, 1'b0, 8'h0C, 25);
        expect_txn({pfx, "_init3"}, 1'b0, 8'h06, 32);
        expect_txn({pfx, "_init4"}, 1'b0, 8'h01, 39);
        wait_busy_low({pfx, "_idle"}, 121);
        expect_line({pfx, "_l0"}, 8'h80, 32'h20202020, 51);
        expect_line({pfx, "_l1"}, 8'hC0, 32'h20202020, 87);
    endtask

    initial begin
        int  c0;
        bit  seen;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_e",    32'(lcd_e),     32'd0);
        check("rst_rs",   32'(lcd_rs),    32'd0);
        check("rst_rw",   32'(lcd_rw),    32'd0);
        check("rst_data", 32'(lcd_data),  32'h00);
        check("rst_init", 32'(init_done), 32'd0);
        check("rst_busy", 32'(busy),      32'd1);
        reset = 1'b1;

        boot_check("boot");
        check("boot_rw", 32'(lcd_rw), 32'd0);

        // Single write to a clean line while idle
        @(negedge clk);
        c0 = cyc;
        write1(1'b1, 2'd2, 8'h41);
        check("single_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_setup_data", 32'(lcd_data), 32'hC0);
        check("single_setup_e",    32'(lcd_e),    32'd0);
        check("single_setup_rs",   32'(lcd_rs),   32'd0);
        expect_line("single_l1", 8'hC0, 32'h20204120, c0 + 3);
        wait_busy_low("single_done", -1);
        check("single_no_l0", 32'(q_d.size()), 32'd0);

        // Priority: line1 and line0 both dirty -> line0 goes first
        write1(1'b1, 2'd0, 8'h42);
        @(negedge clk);
        write1(1'b1, 2'd3, 8'h44);
        write1(1'b0, 2'd0, 8'h45);
        expect_line("prio_l1a", 8'hC0, 32'h42204144, -1);
        expect_line("prio_l0",  8'h80, 32'h45202020, -1);
        expect_line("prio_l1b", 8'hC0, 32'h42204144, -1);
        wait_busy_low("prio_done", -1);
        check("prio_empty", 32'(q_d.size()), 32'd0);

        // Writes landing during the column-1 transaction of line 0
        write1(1'b0, 2'd1, 8'h50);
        expect_txn("mid_addr", 1'b0, 8'h80, -1);
        expect_txn("mid_c0",   1'b1, 8'h45, -1);
        expect_txn("mid_c1",   1'b1, 8'h50, -1);
        write1(1'b0, 2'd3, 8'h5A);
        write1(1'b0, 2'd0, 8'h59);
        expect_txn("mid_c2",   1'b1, 8'h20, -1);
        expect_txn("mid_c3",   1'b1, 8'h5A, -1);
        expect_line("mid_resend", 8'h80, 32'h5950205A, -1);
        wait_busy_low("mid_done", -1);
        check("mid_empty", 32'(q_d.size()), 32'd0);

        // Out-of-range writes on the 1x3 instance
        check("oor_busy_before",  32'(busy2),   32'd0);
        check("oor_rises_before", 32'(n_rise2), 32'd9);
        write2(1'b1, 2'd0, 8'h41);
        write2(1'b0, 2'd3, 8'h41);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (busy2) seen = 1'b1;
        end
        check("oor_busy_seen",   32'(seen),    32'd0);
        check("oor_rises_after", 32'(n_rise2), 32'd9);
        write2(1'b0, 2'd2, 8'h4B);
        check("inrange_busy", 32'(busy2), 32'd1);

        // Asynchronous reset in the middle of an E pulse
        write1(1'b1, 2'd1, 8'h52);
        for (int t = 0; t < 50 && !lcd_e; t++) @(negedge clk);
        check("arst_pre_e", 32'(lcd_e), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_e",    32'(lcd_e),     32'd0);
        check("arst_init", 32'(init_done), 32'd0);
        check("arst_busy", 32'(busy),      32'd1);
        check("arst_data", 32'(lcd_data),  32'h00);
        q_d.delete();
        q_rs.delete();
        q_c.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        boot_check("reboot");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire
